// File: rtl/pool_pkg.sv
// Shared definitions for the pooled-map reader: map-size defaults, FSM states
// and the address-width helper.
package pool_pkg;

  localparam int POOL_MAP_W = 6;
  localparam int POOL_MAP_H = 6;

  // Width needed to index n items; never collapses to zero bits.
  function automatic int pool_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int POOL_AW = pool_width(POOL_MAP_W * POOL_MAP_H);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_LOAD = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } pool_state_e;

endpackage

// File: rtl/pooled_map_reader_if.sv
// Memory-read and output-stream signals of the pooled-map reader.
// master = reader side, slave = memory/downstream side.
interface pooled_map_reader_if
  import pool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MAP_W  = POOL_MAP_W,
  parameter int MAP_H  = POOL_MAP_H
) ();

  localparam int AW = pool_width(MAP_W * MAP_H);

  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  out_data, out_valid, out_last,
    output out_ready
  );

endinterface

// File: rtl/pool_idx_counter.sv
// Row/column walker over the pooled map with row- or column-major order.
// Exposes the current address, the address after one advance, and a final flag.
module pool_idx_counter
  import pool_pkg::*;
#(
  parameter int MAP_W = POOL_MAP_W,
  parameter int MAP_H = POOL_MAP_H,
  parameter int AW    = pool_width(MAP_W * MAP_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  input  logic          col_major,
  output logic [AW-1:0] addr,
  output logic [AW-1:0] next_addr,
  output logic          final_flag
);

  localparam int CW = pool_width(MAP_W);
  localparam int RW = pool_width(MAP_H);
  localparam logic [CW-1:0] C_MAX = CW'(MAP_W - 1);
  localparam logic [RW-1:0] R_MAX = RW'(MAP_H - 1);

  logic [CW-1:0] c, c_n;
  logic [RW-1:0] r, r_n;

  always_comb begin
    c_n = c;
    r_n = r;
    if (col_major) begin
      if (r == R_MAX) begin
        r_n = '0;
        c_n = (c == C_MAX) ? '0 : c + 1'b1;
      end else begin
        r_n = r + 1'b1;
      end
    end else begin
      if (c == C_MAX) begin
        c_n = '0;
        r_n = (r == R_MAX) ? '0 : r + 1'b1;
      end else begin
        c_n = c + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r <= '0;
      c <= '0;
    end else if (advance) begin
      r <= r_n;
      c <= c_n;
    end
  end

  assign addr       = AW'(r)   * AW'(MAP_W) + AW'(c);
  assign next_addr  = AW'(r_n) * AW'(MAP_W) + AW'(c_n);
  assign final_flag = (r == R_MAX) && (c == C_MAX);

endmodule

// File: rtl/pooled_map_reader.sv
// Streams one pooled map from memory, one beat per two cycles at full rate.
// Define POOLED_MAP_READER_CHKSUM_EN to append a mod-2^DATA_W checksum beat.
module pooled_map_reader
  import pool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MAP_W  = POOL_MAP_W,
  parameter int MAP_H  = POOL_MAP_H
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 col_major,
  pooled_map_reader_if.master  bus,
  output logic                 idle,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int AW = pool_width(MAP_W * MAP_H);

  pool_state_e       state, state_n;
  logic              col_major_q;
  logic              cnt_clear, cnt_adv, final_flag, hs;
  logic [AW-1:0]     cur_addr, next_addr;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_last, error_q;
`ifdef POOLED_MAP_READER_CHKSUM_EN
  logic [DATA_W-1:0] acc;
  logic              chk_q;
`endif

  pool_idx_counter #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H),
    .AW    (AW)
  ) u_idx (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .advance    (cnt_adv),
    .col_major  (col_major_q),
    .addr       (cur_addr),
    .next_addr  (next_addr),
    .final_flag (final_flag)
  );

  assign hs = (state == ST_HOLD) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // A non-final handshake issues the next read in the same cycle so the
  // memory latency overlaps the beat transfer.
  always_comb begin
    state_n   = state;
    rd_en     = 1'b0;
    rd_addr   = cur_addr;
    cnt_clear = 1'b0;
    cnt_adv   = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_n   = ST_READ;
        end
      end
      ST_READ: begin
        rd_en   = 1'b1;
        state_n = ST_LOAD;
      end
      ST_LOAD: state_n = ST_HOLD;
      ST_HOLD: begin
        if (bus.out_ready) begin
          if (final_flag) begin
`ifdef POOLED_MAP_READER_CHKSUM_EN
            state_n = chk_q ? ST_DONE : ST_HOLD;
`else
            state_n = ST_DONE;
`endif
          end else begin
            rd_en   = 1'b1;
            rd_addr = next_addr;
            cnt_adv = 1'b1;
            state_n = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      error_q     <= 1'b0;
      col_major_q <= 1'b0;
`ifdef POOLED_MAP_READER_CHKSUM_EN
      acc         <= '0;
      chk_q       <= 1'b0;
`endif
    end else begin
      error_q <= start && (state != ST_IDLE);
      if ((state == ST_IDLE) && start) begin
        col_major_q <= col_major;
`ifdef POOLED_MAP_READER_CHKSUM_EN
        acc         <= '0;
        chk_q       <= 1'b0;
`endif
      end
      if (state == ST_LOAD) begin
        out_data  <= bus.rd_data;
        out_valid <= 1'b1;
`ifdef POOLED_MAP_READER_CHKSUM_EN
        out_last  <= 1'b0;
`else
        out_last  <= final_flag;
`endif
      end else if (hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
`ifdef POOLED_MAP_READER_CHKSUM_EN
        // The checksum beat reuses HOLD directly; no memory read is issued.
        if (!chk_q) begin
          acc <= acc + out_data;
          if (final_flag) begin
            out_data  <= acc + out_data;
            out_valid <= 1'b1;
            out_last  <= 1'b1;
            chk_q     <= 1'b1;
          end
        end
`endif
      end
    end
  end

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_addr;
  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign idle          = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign error         = error_q;

endmodule

// File: doc/pooled_map_reader.md
POOLED_MAP_READER -- requirements
Module: pooled_map_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, element width in bits.
REQ-002 SHALL have parameter MAP_W, default 6, pooled-map columns.
REQ-003 SHALL have parameter MAP_H, default 6, pooled-map rows.
REQ-004 SHALL have one clock and one reset: the design is on one clock, and reset is synchronous and active-high.
REQ-005 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port start  input  1  request to stream one full pooled map.
REQ-008 SHALL have port col_major  input  1  read-order select, 0 row-major, 1 column-major; sampled with start.
REQ-009 SHALL have port rd_en  output  1  pooled-map memory read strobe.
REQ-010 SHALL have port rd_addr  output  AW=$clog2(MAP_W*MAP_H)  memory address, r*MAP_W+c.
REQ-011 SHALL have port rd_data  input  DATA_W  memory data, valid exactly one cycle after rd_en.
REQ-012 SHALL have port out_data  output  DATA_W  streamed element.
REQ-013 SHALL have port out_valid  output  1  out_data valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-015 SHALL have port out_last  output  1  marks final beat of the map.
REQ-016 SHALL have port idle  output  1  ready for start.
REQ-017 SHALL have port busy  output  1  streaming in progress, equal to !idle.
REQ-018 SHALL have port done  output  1  one-cycle completion pulse.
REQ-019 SHALL have port error  output  1  one-cycle pulse on start while busy.

Function
REQ-020 SHALL implement states IDLE, READ, LOAD, HOLD, DONE.
REQ-021 IDLE with start=1 SHALL capture col_major, clear row/col counters, and go to READ.
REQ-022 READ SHALL drive rd_en=1 and rd_addr for the current (r,c), then go to LOAD.
REQ-023 LOAD SHALL register rd_data into out_data, set out_valid=1, and go to HOLD.
REQ-024 HOLD SHALL keep out_data, out_valid and out_last stable until out_ready=1.
REQ-025 A HOLD handshake on a non-final element SHALL advance the counters, assert rd_en for the next address in that same cycle, and go to LOAD; throughput is one beat per 2 cycles with out_ready held at 1.
REQ-026 A HOLD handshake on the final beat SHALL go to DONE; DONE SHALL pulse done=1 for one cycle and then return to IDLE.
REQ-027 Latency SHALL be: start sampled at edge 0, rd_en high in cycle 1, out_valid high from cycle 3.
REQ-028 Row-major order SHALL increment c first and wrap c from MAP_W-1 to 0 with r+1; column-major order SHALL increment r first and wrap r from MAP_H-1 to 0 with c+1.
REQ-029 out_last SHALL be 1 only on the final beat.
REQ-030 start outside IDLE SHALL be ignored and SHALL pulse error for one cycle.
REQ-031 out_valid SHALL never be 1 in IDLE, READ or DONE.
REQ-032 rd_en SHALL be 0 except as stated in REQ-022 and REQ-025.

Reset
REQ-033 In any state, rst=1 SHALL force IDLE at the next edge, with no done pulse.
REQ-034 Reset SHALL clear out_valid, out_last, rd_en, done and error to 0, set idle=1 and busy=0, and zero out_data, the counters and the checksum accumulator.

Configuration
REQ-035 With POOLED_MAP_READER_CHKSUM_EN defined, the block SHALL accumulate a mod-2^DATA_W sum of all handshaked elements and emit it as one extra HOLD beat after element MAP_W*MAP_H-1, with no memory read; out_last SHALL be on that checksum beat.
REQ-036 Without POOLED_MAP_READER_CHKSUM_EN, the block SHALL have no accumulator, and out_last SHALL be on element MAP_W*MAP_H-1.

Structure
REQ-037 Shared package pool_pkg SHALL hold the MAP_W/MAP_H defaults, the state enum and the address-width constant.
REQ-038 Sub-module pool_idx_counter SHALL implement the row/col counters with order select and a final flag.

Verification
REQ-039 Bench SHALL check: mem[a]=a, row-major, out_ready=1 -> beats 0..35 each 2 cycles apart, out_last on 35, done one cycle after the last handshake.
REQ-040 Bench SHALL check: col_major=1 -> beat order 0,6,12,18,24,30,1,7,...,35.
REQ-041 Bench SHALL check: out_ready low 5 cycles on beat 3 -> out_data=3 held stable, no rd_en, stream resumes with 4.
REQ-042 Bench SHALL check: start pulsed during beat 10 -> error=1 for one cycle, stream unaffected.
REQ-043 Bench SHALL check: rst at beat 10 -> idle=1 next cycle, no done, a new start restarts at address 0.
REQ-044 Bench SHALL check: with CHKSUM_EN and mem[a]=a -> 37th beat = 0x76, out_last only on that beat.
